hub_rx_jabber: RTL and testbench

- Per-port receive-side guard placed between each port's PCS receive MII and the hub repeater core's rx_dv/rx_er/rxd inputs; the top level instantiates one per port.
- Passes frames through with one cycle of registered latency.
- Implements the repeater jabber function: a port whose carrier stays up longer than JABBER_MAX cycles is cut off and held off until it has been quiet for UNJAB cycles.
- Provides jabber status and a saturating event counter for management.

---
 rtl/hub_pkg.sv | 15 +
 rtl/hub_sat_counter.sv | 30 +++
 rtl/hub_rx_jabber.sv | 143 ++++++++++++++
 tb/tb_hub_rx_jabber.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hub_pkg.sv
// Shared hub definitions: MII width, default jabber timing and the receive guard state encoding.
package hub_pkg;

  localparam int unsigned MiiW             = 4;
  localparam int unsigned JabberMaxDefault = 15000;
  localparam int unsigned UnjabDefault     = 28;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPass   = 2'd1,
    StJabber = 2'd2,
    StUnjab  = 2'd3
  } jab_state_e;

endpackage

// File: rtl/hub_sat_counter.sv
// Saturating up-counter with enable; holds at all ones once reached.
module hub_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && !(&count_q)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hub_rx_jabber.sv
// Per-port receive jabber guard: registered pass-through that cuts off an over-long carrier
// and holds the port off until it has been quiet long enough.
module hub_rx_jabber
  import hub_pkg::*;
#(
  parameter int unsigned JABBER_MAX = JabberMaxDefault,
  parameter int unsigned UNJAB      = UnjabDefault,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_dv,
  input  logic                rx_er,
  input  logic [MiiW-1:0]     rxd,
  output logic                rx_dv_out,
  output logic                rx_er_out,
  output logic [MiiW-1:0]     rxd_out,
  output logic                jabber,
  output logic [CNT_BITS-1:0] jabber_count
);

  localparam int unsigned LenW   = $clog2(JABBER_MAX + 2);
  localparam int unsigned QuietW = (UNJAB == 0) ? 1 : $clog2(UNJAB + 1);

  localparam logic [LenW-1:0]   LenMax    = LenW'(JABBER_MAX);
  localparam logic [QuietW-1:0] QuietLast = (UNJAB > 1) ? QuietW'(UNJAB - 1) : '0;

  jab_state_e        state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [QuietW-1:0] quiet_q, quiet_d;
  logic              trip;

  logic            dv_d, er_d, jabber_d;
  logic [MiiW-1:0] rxd_d;
  logic            dv_q, er_q, jabber_q;
  logic [MiiW-1:0] rxd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      quiet_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      quiet_q <= quiet_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    quiet_d = quiet_q;
    trip    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_dv) begin
          state_d = StPass;
          len_d   = LenW'(1);
        end
      end
      StPass: begin
        if (!rx_dv) begin
          state_d = StIdle;
          len_d   = '0;
        end else if (len_q == LenMax) begin
          state_d = StJabber;
          len_d   = '0;
          trip    = 1'b1;
        end else begin
          len_d = len_q + LenW'(1);
        end
      end
      StJabber: begin
        if (!rx_dv) begin
          // A single required quiet cycle is already satisfied by this one.
          if (UNJAB <= 1) begin
            state_d = StIdle;
          end else begin
            state_d = StUnjab;
            quiet_d = QuietW'(1);
          end
        end
      end
      StUnjab: begin
        if (rx_dv) begin
          quiet_d = '0;
        end else if (quiet_q == QuietLast) begin
          state_d = StIdle;
          quiet_d = '0;
        end else begin
          quiet_d = quiet_q + QuietW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs for the next edge; the trip nibble is repeated with rx_er forced to corrupt the frame.
  always_comb begin
    dv_d     = 1'b0;
    er_d     = 1'b0;
    rxd_d    = '0;
    jabber_d = (state_d == StJabber) || (state_d == StUnjab);
    unique case (state_q)
      StIdle, StPass: begin
        dv_d  = rx_dv;
        er_d  = rx_er | trip;
        rxd_d = rxd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q     <= 1'b0;
      er_q     <= 1'b0;
      rxd_q    <= '0;
      jabber_q <= 1'b0;
    end else begin
      dv_q     <= dv_d;
      er_q     <= er_d;
      rxd_q    <= rxd_d;
      jabber_q <= jabber_d;
    end
  end

  hub_sat_counter #(
    .Width(CNT_BITS)
  ) u_jabber_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (trip),
    .count(jabber_count)
  );

  assign rx_dv_out = dv_q;
  assign rx_er_out = er_q;
  assign rxd_out   = rxd_q;
  assign jabber    = jabber_q;

endmodule

// File: tb/tb_hub_rx_jabber.sv
// Bench for hub_rx_jabber: directed scenarios plus random frames against a run-length model.
module tb_hub_rx_jabber;

  localparam int JMAX = 20;
  localparam int UNJ  = 4;

  logic        clk;
  logic        rst_n;
  logic        rx_dv;
  logic        rx_er;
  logic [3:0]  rxd;
  logic        dv1, er1, jab1;
  logic [3:0]  rxd1;
  logic [15:0] cnt1;
  logic        dv2, er2, jab2;
  logic [3:0]  rxd2;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  // Model state: length of the current carrier, lockout flag, quiet run since lockout, events.
  int m_run    = 0;
  bit m_cut    = 0;
  int m_quiet  = 0;
  int m_events = 0;

  hub_rx_jabber #(.JABBER_MAX(JMAX), .UNJAB(UNJ), .CNT_BITS(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .rx_dv_out(dv1), .rx_er_out(er1), .rxd_out(rxd1), .jabber(jab1), .jabber_count(cnt1)
  );

  hub_rx_jabber #(.JABBER_MAX(JMAX), .UNJAB(UNJ), .CNT_BITS(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .rx_dv_out(dv2), .rx_er_out(er2), .rxd_out(rxd2), .jabber(jab2), .jabber_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic edv, input logic eer, input logic [3:0] ed);
    int sat;
    sat = (m_events > 3) ? 3 : m_events;
    check("rx_dv_out", 32'(dv1), 32'(edv));
    check("rx_er_out", 32'(er1), 32'(eer));
    check("rxd_out", 32'(rxd1), 32'(ed));
    check("jabber", 32'(jab1), 32'(m_cut));
    check("jabber_count", 32'(cnt1), 32'(m_events));
    check("sat_rx_dv_out", 32'(dv2), 32'(edv));
    check("sat_rx_er_out", 32'(er2), 32'(eer));
    check("sat_rxd_out", 32'(rxd2), 32'(ed));
    check("sat_jabber", 32'(jab2), 32'(m_cut));
    check("sat_jabber_count", 32'(cnt2), 32'(sat));
  endtask

  task automatic model_reset();
    m_run    = 0;
    m_cut    = 0;
    m_quiet  = 0;
    m_events = 0;
  endtask

  // Drive one cycle of input, predict the next registered output, and compare after the edge.
  task automatic step(input logic dv, input logic er, input logic [3:0] d);
    logic       edv, eer;
    logic [3:0] ed;
    rx_dv = dv;
    rx_er = er;
    rxd   = d;
    if (!m_cut) begin
      edv = dv;
      ed  = d;
      eer = er;
      if (dv) begin
        m_run++;
        if (m_run > JMAX) begin
          eer = 1'b1;
          m_cut = 1'b1;
          m_quiet = 0;
          m_events++;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      edv = 1'b0;
      eer = 1'b0;
      ed  = 4'h0;
      if (dv) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet >= UNJ) begin
          m_cut = 1'b0;
          m_quiet = 0;
          m_run = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(edv, eer, ed);
  endtask

  task automatic frame(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 4'(start + i));
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 4'h0);
    end
  endtask

  initial begin
    int sat_exp [5];
    sat_exp = '{1, 2, 3, 3, 3};
    rst_n = 1'b0;
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rxd   = 4'h0;
    #12;
    check_all(1'b0, 1'b0, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Short frame, exact-limit frame, over-limit frame with carrier during unjab.
    gap(2);
    frame(10, 0);
    gap(3);
    frame(JMAX, 5);
    gap(3);
    frame(30, 0);
    check("count_after_trip", 32'(cnt1), 32'd1);
    gap(2);
    frame(3, 7);
    gap(3);
    check("jabber_before_last_quiet", 32'(jab1), 32'd1);
    gap(1);
    check("jabber_after_unjab", 32'(jab1), 32'd0);
    frame(5, 3);
    gap(2);

    // Asynchronous reset while locked out.
    frame(JMAX + 3, 1);
    rx_dv = 1'b0;
    rxd   = 4'h0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(1'b0, 1'b0, 4'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    gap(1);
    frame(6, 9);
    gap(2);

    // Counter saturation on the 2-bit instance.
    for (int k = 0; k < 5; k++) begin
      frame(JMAX + 2, k);
      check("sat_count_seq", 32'(cnt2), 32'(sat_exp[k]));
      gap(UNJ + 1);
    end

    // Random carrier bursts and gaps with random error and data.
    for (int n = 0; n < 300; n++) begin
      int hi, lo;
      hi = $urandom_range(1, JMAX + 10);
      lo = $urandom_range(1, UNJ + 3);
      for (int i = 0; i < hi; i++) begin
        step(1'b1, 1'($urandom_range(0, 7) == 0), 4'($urandom));
      end
      for (int i = 0; i < lo; i++) begin
        step(1'b0, 1'($urandom_range(0, 3) == 0), 4'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
